measure_object_bbox: RTL and testbench
======================================

Name: measure_object_bbox

Overview:
- Per-frame object locator and successor to the single-frame centroid block: accumulates pixel count, x/y sums and bounding box over every pixel whose delta magnitude meets a programmable threshold.
- At end of frame, computes the centroid with a multi-cycle sequential divider instead of a combinational divide, then publishes centroid, bounding box and count with a one-cycle valid pulse.
- Sits after the frame-difference stage and feeds the overlay and tracking logic.

Parameters:
- INPUT_WIDTH, 11, width of vga_x/vga_y and of all position outputs
- COLOR_WIDTH, 10, width of delta_frame
- FRAME_X_MAX, 640, x coordinate marking end of frame; pixels with x >= this are ignored
- FRAME_Y_MAX, 480, y coordinate marking end of frame; pixels with y >= this are ignored
- COUNT_THRESH, 40, minimum pixel count for a valid object
- PIXEL_THRESH, 2**COLOR_WIDTH-1, delta_frame >= PIXEL_THRESH marks an object pixel
- COUNT_WIDTH, 19, pixel counter width
- SUM_WIDTH, 28, coordinate sum width; also the number of divider iterations

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- enable  in  1  synchronous run enable; low clears the block
- vga_x  in  INPUT_WIDTH  current pixel x
- vga_y  in  INPUT_WIDTH  current pixel y
- delta_frame  in  COLOR_WIDTH  frame-difference magnitude for the current pixel
- x_position  out  INPUT_WIDTH  centroid x
- y_position  out  INPUT_WIDTH  centroid y
- x_min, x_max, y_min, y_max  out  INPUT_WIDTH each  bounding box
- pixel_count  out  COUNT_WIDTH  object pixel count of the last completed frame
- object_found  out  1  last result had count >= COUNT_THRESH
- valid  out  1  one-cycle pulse when all outputs update
- busy  out  1  divider running (state != IDLE)
- overrun  out  1  one-cycle pulse when end of frame arrives while busy

Behaviour:
- Reset (aresetn low, asynchronous):
  - All outputs 0.
  - Accumulators: count = 0, sums = 0, min = all-ones, max = 0.
  - FSM enters IDLE.
- enable low: same values as reset, applied synchronously. No valid is produced and any divide in progress is aborted.
- EOF is defined as vga_x == FRAME_X_MAX && vga_y == FRAME_Y_MAX.
- Accumulate (every enabled non-EOF cycle) when vga_x < FRAME_X_MAX, vga_y < FRAME_Y_MAX and delta_frame >= PIXEL_THRESH:
  - count += 1, saturating at all-ones.
  - sum_x += vga_x; sum_y += vga_y.
  - min/max update as a running compare.
- EOF cycle:
  - Snapshot the accumulators into working registers and clear the accumulators in the same cycle. The EOF pixel itself is never counted.
  - Snapshot is taken only if the FSM is IDLE. Otherwise the snapshot is dropped, overrun pulses, and the accumulators still clear.
- FSM states: IDLE, DIV, DONE.
  - IDLE -> DIV at EOF if snapshot count >= COUNT_THRESH. Iteration counter is loaded with SUM_WIDTH-1.
  - IDLE -> DONE at EOF if count < COUNT_THRESH. The result is forced to all-ones for positions and bounding box; object_found = 0.
  - DIV: restoring division, one quotient bit per cycle, x and y in parallel, shared divisor = count. After SUM_WIDTH cycles -> DONE.
  - DONE: register the outputs and pulse valid for exactly one cycle -> IDLE.
- Output formatting:
  - Quotient is truncated (floor), and its low INPUT_WIDTH bits drive the position outputs.
  - pixel_count always reports the snapshot count, even below threshold.
- Latency, counting from the clock edge that samples EOF:
  - valid is high SUM_WIDTH+2 edges later for a found object.
  - valid is high 2 edges later for below-threshold frames.
- Outputs hold their values between valid pulses.
- busy is high in DIV and DONE.
- Width rule: SUM_WIDTH must be >= ceil(log2(FRAME_X_MAX*FRAME_Y_MAX*FRAME_X_MAX)). Under that rule the sums cannot overflow.

Test Plan (bench overrides FRAME_X_MAX=16, FRAME_Y_MAX=8, COUNT_THRESH=4, SUM_WIDTH=12, raster scan including EOF cycle):
- Block x=4..7, y=2..3 with delta=1023, rest 0 -> valid once, SUM_WIDTH+2 edges after EOF; pixel_count=8, x_position=5, y_position=2, bbox (4,7,2,3), object_found=1.
- 3 object pixels -> valid 2 edges after EOF; positions and bbox = 2047, pixel_count=3, object_found=0.
- PIXEL_THRESH=512: pixels at (1,1)=511 and (2,1)..(5,1)=512 -> pixel_count=4, x_position=3, y_position=1, x_min=2.
- enable dropped mid-DIV for 1 cycle -> all outputs 0, no valid, busy=0. The next full frame produces a correct result.
- aresetn pulsed mid-frame -> outputs 0 immediately (asynchronous). The following frame counts only post-reset pixels.
- Second EOF injected 5 cycles after the first, during DIV -> overrun pulses once; the first result completes with correct values; no second valid.

Source files
------------

// File: rtl/measure_object_bbox.sv
// rtl/measure_object_bbox.sv - per-frame object centroid, bounding box and pixel count
// Accumulates thresholded pixels, then divides sums by count with a restoring divider at end of frame.
module measure_object_bbox #(
  parameter int INPUT_WIDTH  = 11,
  parameter int COLOR_WIDTH  = 10,
  parameter int FRAME_X_MAX  = 640,
  parameter int FRAME_Y_MAX  = 480,
  parameter int COUNT_THRESH = 40,
  parameter int PIXEL_THRESH = 2**COLOR_WIDTH-1,
  parameter int COUNT_WIDTH  = 19,
  parameter int SUM_WIDTH    = 28
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] vga_x,
  input  logic [INPUT_WIDTH-1:0] vga_y,
  input  logic [COLOR_WIDTH-1:0] delta_frame,
  output logic [INPUT_WIDTH-1:0] x_position,
  output logic [INPUT_WIDTH-1:0] y_position,
  output logic [INPUT_WIDTH-1:0] x_min,
  output logic [INPUT_WIDTH-1:0] x_max,
  output logic [INPUT_WIDTH-1:0] y_min,
  output logic [INPUT_WIDTH-1:0] y_max,
  output logic [COUNT_WIDTH-1:0] pixel_count,
  output logic                   object_found,
  output logic                   valid,
  output logic                   busy,
  output logic                   overrun
);
  localparam int ITW = $clog2(SUM_WIDTH);
  localparam logic [INPUT_WIDTH-1:0] X_END     = INPUT_WIDTH'(FRAME_X_MAX);
  localparam logic [INPUT_WIDTH-1:0] Y_END     = INPUT_WIDTH'(FRAME_Y_MAX);
  localparam logic [COLOR_WIDTH-1:0] PIX_T     = COLOR_WIDTH'(PIXEL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] CNT_T     = COUNT_WIDTH'(COUNT_THRESH);
  localparam logic [ITW-1:0]         ITER_LAST = ITW'(SUM_WIDTH-1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic eof, hit, acc_found, take, drop, step, publish;
  logic [COUNT_WIDTH-1:0] acc_count;
  logic [SUM_WIDTH-1:0]   acc_sum_x, acc_sum_y;
  logic [INPUT_WIDTH-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;

  logic [COUNT_WIDTH-1:0] w_count;
  logic                   w_found;
  logic [SUM_WIDTH-1:0]   quo_x, quo_y;
  logic [COUNT_WIDTH-1:0] rem_x, rem_y;
  logic [INPUT_WIDTH-1:0] w_x_min, w_x_max, w_y_min, w_y_max;
  logic [ITW-1:0]         iter;

  logic [COUNT_WIDTH:0] sh_x, sh_y, dv, df_x, df_y;
  logic                 ge_x, ge_y;

  assign eof       = enable && vga_x == X_END && vga_y == Y_END;
  assign hit       = enable && vga_x < X_END && vga_y < Y_END && delta_frame >= PIX_T;
  assign acc_found = acc_count >= CNT_T;

  // One restoring-division step for each axis; both share the pixel count as divisor.
  always_comb begin
    dv   = {1'b0, w_count};
    sh_x = {rem_x, quo_x[SUM_WIDTH-1]};
    sh_y = {rem_y, quo_y[SUM_WIDTH-1]};
    ge_x = sh_x >= dv;
    ge_y = sh_y >= dv;
    df_x = sh_x - dv;
    df_y = sh_y - dv;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (eof) state_nxt = acc_found ? DIV : DONE;
        DIV:     if (iter == '0) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = state != IDLE;
    take    = eof && state == IDLE;
    drop    = eof && state != IDLE;
    step    = enable && state == DIV;
    publish = enable && state == DONE;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_count <= '0; acc_sum_x <= '0; acc_sum_y <= '0;
      acc_x_min <= '1; acc_x_max <= '0; acc_y_min <= '1; acc_y_max <= '0;
    end else if (!enable || eof) begin
      acc_count <= '0; acc_sum_x <= '0; acc_sum_y <= '0;
      acc_x_min <= '1; acc_x_max <= '0; acc_y_min <= '1; acc_y_max <= '0;
    end else if (hit) begin
      if (acc_count != '1) acc_count <= acc_count + 1'b1;
      acc_sum_x <= acc_sum_x + SUM_WIDTH'(vga_x);
      acc_sum_y <= acc_sum_y + SUM_WIDTH'(vga_y);
      if (vga_x < acc_x_min) acc_x_min <= vga_x;
      if (vga_x > acc_x_max) acc_x_max <= vga_x;
      if (vga_y < acc_y_min) acc_y_min <= vga_y;
      if (vga_y > acc_y_max) acc_y_max <= vga_y;
    end
  end

  // Quotient bits shift into the low end of the dividend registers as the sums shift out.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_count <= '0; w_found <= 1'b0; quo_x <= '0; quo_y <= '0; rem_x <= '0; rem_y <= '0;
      w_x_min <= '0; w_x_max <= '0; w_y_min <= '0; w_y_max <= '0; iter <= '0;
    end else if (!enable) begin
      w_count <= '0; w_found <= 1'b0; quo_x <= '0; quo_y <= '0; rem_x <= '0; rem_y <= '0;
      w_x_min <= '0; w_x_max <= '0; w_y_min <= '0; w_y_max <= '0; iter <= '0;
    end else if (take) begin
      w_count <= acc_count; w_found <= acc_found;
      quo_x   <= acc_sum_x; quo_y   <= acc_sum_y;
      rem_x   <= '0;        rem_y   <= '0;
      w_x_min <= acc_x_min; w_x_max <= acc_x_max;
      w_y_min <= acc_y_min; w_y_max <= acc_y_max;
      iter    <= ITER_LAST;
    end else if (step) begin
      quo_x <= {quo_x[SUM_WIDTH-2:0], ge_x};
      quo_y <= {quo_y[SUM_WIDTH-2:0], ge_y};
      rem_x <= ge_x ? df_x[COUNT_WIDTH-1:0] : sh_x[COUNT_WIDTH-1:0];
      rem_y <= ge_y ? df_y[COUNT_WIDTH-1:0] : sh_y[COUNT_WIDTH-1:0];
      if (iter != '0) iter <= iter - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_position <= '0; y_position <= '0; x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
      pixel_count <= '0; object_found <= 1'b0; valid <= 1'b0; overrun <= 1'b0;
    end else if (!enable) begin
      x_position <= '0; y_position <= '0; x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
      pixel_count <= '0; object_found <= 1'b0; valid <= 1'b0; overrun <= 1'b0;
    end else begin
      valid   <= publish;
      overrun <= drop;
      if (publish) begin
        x_position   <= w_found ? quo_x[INPUT_WIDTH-1:0] : '1;
        y_position   <= w_found ? quo_y[INPUT_WIDTH-1:0] : '1;
        x_min        <= w_found ? w_x_min : '1;
        x_max        <= w_found ? w_x_max : '1;
        y_min        <= w_found ? w_y_min : '1;
        y_max        <= w_found ? w_y_max : '1;
        pixel_count  <= w_count;
        object_found <= w_found;
      end
    end
  end
endmodule

// File: tb/tb_measure_object_bbox.sv
// tb/tb_measure_object_bbox.sv - scoreboard bench for measure_object_bbox
// Frames are raster-scanned; a pixel-array reference model predicts each result into a queue.
module tb_measure_object_bbox;
  localparam int SW  = 12;
  localparam int THR = 512;
  localparam int CT  = 4;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b1;
  logic [10:0] vga_x = 11'd17, vga_y = 11'd9;
  logic [9:0]  delta_frame = '0;
  logic [10:0] x_position, y_position, x_min, x_max, y_min, y_max;
  logic [18:0] pixel_count;
  logic        object_found, valid, busy, overrun;

  measure_object_bbox #(
    .FRAME_X_MAX(16), .FRAME_Y_MAX(8), .COUNT_THRESH(CT),
    .PIXEL_THRESH(THR), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable),
    .vga_x(vga_x), .vga_y(vga_y), .delta_frame(delta_frame),
    .x_position(x_position), .y_position(y_position),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pixel_count(pixel_count), .object_found(object_found),
    .valid(valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt; int xp; int yp; int xmn; int xmx; int ymn; int ymx; int found; int vcyc;
  } exp_t;

  exp_t expq[$];
  int   img[8][16];
  int   cyc = 0;
  int   n_cmp = 0, n_fail = 0, n_ovr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain sums over the pixel array, divide with integer floor.
  function automatic exp_t model(input int first_row, input int e);
    exp_t r;
    int sx = 0, sy = 0;
    r.cnt = 0; r.xmn = 2047; r.xmx = 0; r.ymn = 2047; r.ymx = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        if (y >= first_row && img[y][x] >= THR) begin
          r.cnt++; sx += x; sy += y;
          if (x < r.xmn) r.xmn = x;
          if (x > r.xmx) r.xmx = x;
          if (y < r.ymn) r.ymn = y;
          if (y > r.ymx) r.ymx = y;
        end
    r.found = (r.cnt >= CT) ? 1 : 0;
    if (r.found == 1) begin
      r.xp = (sx / r.cnt) % 2048;
      r.yp = (sy / r.cnt) % 2048;
    end else begin
      r.xp = 2047; r.yp = 2047; r.xmn = 2047; r.xmx = 2047; r.ymn = 2047; r.ymx = 2047;
    end
    // valid is set by edge e+SW+1 (found) or e+1, so the edge e+SW+2 / e+2 samples it high
    r.vcyc = e + ((r.found == 1) ? SW + 1 : 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (overrun) n_ovr++;
    if (valid) begin
      if (expq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("latency", cyc, e.vcyc);
        check("pixel_count", int'(pixel_count), e.cnt);
        check("object_found", int'(object_found), e.found);
        check("x_position", int'(x_position), e.xp);
        check("y_position", int'(y_position), e.yp);
        check("x_min", int'(x_min), e.xmn);
        check("x_max", int'(x_max), e.xmx);
        check("y_min", int'(y_min), e.ymn);
        check("y_max", int'(y_max), e.ymx);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_x_position"}, int'(x_position), 0);
    check({tag, "_y_position"}, int'(y_position), 0);
    check({tag, "_x_min"}, int'(x_min), 0);
    check({tag, "_x_max"}, int'(x_max), 0);
    check({tag, "_y_min"}, int'(y_min), 0);
    check({tag, "_y_max"}, int'(y_max), 0);
    check({tag, "_pixel_count"}, int'(pixel_count), 0);
    check({tag, "_object_found"}, int'(object_found), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vga_x = 11'd17; vga_y = 11'd9; delta_frame = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 0;
  endtask

  // Raster scan with two blanking pixels per line, then the EOF cycle and one idle pixel.
  task automatic run_frame(input int reset_row, input bit push);
    int e;
    for (int y = 0; y < 8; y++) begin
      if (y == reset_row) begin
        @(negedge clk);
        vga_x = 11'd17; vga_y = 11'd9;
        aresetn = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        aresetn = 1'b1;
      end
      for (int x = 0; x < 18; x++) begin
        @(negedge clk);
        vga_x = 11'(x); vga_y = 11'(y);
        delta_frame = (x < 16) ? 10'(img[y][x]) : 10'($urandom_range(0, 1023));
      end
    end
    @(negedge clk);
    vga_x = 11'd16; vga_y = 11'd8; delta_frame = 10'($urandom_range(0, 1023));
    e = cyc + 1;
    if (push) expq.push_back(model(reset_row, e));
    idle(1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      check("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    idle(2);
  endtask

  task automatic block_obj();
    clear_img();
    for (int y = 2; y <= 3; y++)
      for (int x = 4; x <= 7; x++) img[y][x] = 1023;
  endtask

  initial begin
    int ovr0;
    idle(3);
    check_zero("reset");
    aresetn = 1'b1;
    idle(2);

    block_obj();
    run_frame(-1, 1);
    wait_drain();

    clear_img();
    img[0][0] = 1023; img[5][9] = 700; img[7][15] = 512;
    run_frame(-1, 1);
    wait_drain();

    clear_img();
    img[1][1] = 511;
    for (int x = 2; x <= 5; x++) img[1][x] = 512;
    run_frame(-1, 1);
    wait_drain();

    for (int f = 0; f < 8; f++) begin
      int dens;
      dens = (f == 0) ? 100 : $urandom_range(0, 12);
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 16; x++)
          img[y][x] = ($urandom_range(0, 99) < dens) ? $urandom_range(THR, 1023)
                                                      : $urandom_range(0, THR - 1);
      run_frame(-1, 1);
    end
    wait_drain();

    block_obj();
    run_frame(-1, 0);
    idle(3);
    check("busy_in_div", int'(busy), 1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    check_zero("enable_drop");
    idle(20);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) img[y][x] = ((x + y) % 3 == 0) ? 900 : 100;
    run_frame(-1, 1);
    wait_drain();

    block_obj();
    img[0][0] = 1023; img[1][15] = 1023; img[6][3] = 1023; img[7][10] = 1023;
    run_frame(4, 1);
    wait_drain();

    ovr0 = n_ovr;
    block_obj();
    img[6][12] = 600;
    run_frame(-1, 1);
    idle(3);
    @(negedge clk);
    vga_x = 11'd16; vga_y = 11'd8;
    idle(1);
    wait_drain();
    idle(20);
    check("overrun_pulses", n_ovr - ovr0, 1);
    check("overrun_total", n_ovr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
